// File: rtl/point_spawn_ctrl_pkg.sv
// Shared types and helpers for the snake game map logic.
// Provides game_mode, tile_t, spawn_state_t, map size constants, lfsr5 and fold.
package point_spawn_ctrl_pkg;

    typedef enum logic [1:0] {MENU, GAME, OVER} game_mode;

    typedef enum logic [1:0] {EMPTY, SNAKE1, SNAKE2, POINT} tile_t;

    typedef enum logic [1:0] {IDLE, PROBE, CHECK, WRITE} spawn_state_t;

    localparam int MAP_WIDTH       = 32;
    localparam int MAP_HEIGHT      = 24;
    localparam int POINT_MAX_TRIES = 8;

    // 5-bit pseudo-random step used to derive the next candidate.
    function automatic logic [4:0] lfsr5(input logic [4:0] v);
        return {v[3], v[2], v[1], v[0] ^ v[4], v[4]};
    endfunction

    // Map a raw value into the interior range 1..span, skipping the border.
    function automatic logic [4:0] fold(input logic [4:0] v, input int span);
        return 5'(int'(v) % span + 1);
    endfunction

endpackage

// File: rtl/point_spawn_ctrl_if.sv
// Map access bus: one-tile read probe and one-tile POINT write.
// master = spawn controller, slave = map register.
interface point_spawn_ctrl_if
    import point_spawn_ctrl_pkg::*;
();
    logic [4:0] rd_x;
    logic [4:0] rd_y;
    tile_t      rd_tile;
    logic       wr_en;
    logic [4:0] wr_x;
    logic [4:0] wr_y;

    modport master (
        output rd_x, rd_y, wr_en, wr_x, wr_y,
        input  rd_tile
    );

    modport slave (
        input  rd_x, rd_y, wr_en, wr_x, wr_y,
        output rd_tile
    );
endinterface

// File: rtl/point_spawn_ctrl_eat_arbiter.sv
// Round-robin arbiter for snake eat events; holds pend flags and rr pointer.
// Ports: clk/rst, game (mode is GAME), eat1/eat2 pulses, take (FSM can accept),
// grant/grant_id (request accepted this cycle and which snake).
module point_spawn_ctrl_eat_arbiter (
    input  logic clk,
    input  logic rst,
    input  logic game,
    input  logic eat1,
    input  logic eat2,
    input  logic take,
    output logic grant,
    output logic grant_id
);
    logic pend1;
    logic pend2;
    logic rr;

    assign grant    = take & (pend1 | pend2);
    assign grant_id = (pend1 & pend2) ? rr : pend2;

    always_ff @(posedge clk) begin
        if (rst) begin
            pend1 <= 1'b0;
            pend2 <= 1'b0;
            rr    <= 1'b0;
        end else if (!game) begin
            pend1 <= 1'b0;
            pend2 <= 1'b0;
        end else begin
            // A fresh pulse wins over the clear so it is never lost.
            if (eat1)
                pend1 <= 1'b1;
            else if (grant && !grant_id)
                pend1 <= 1'b0;
            if (eat2)
                pend2 <= 1'b1;
            else if (grant && grant_id)
                pend2 <= 1'b0;
            // Point at the other snake after every grant.
            if (grant)
                rr <= ~grant_id;
        end
    end
endmodule

// File: rtl/point_spawn_ctrl.sv
// Places the single POINT tile: arbitrates eats, probes the map, retries, writes.
// Ports: clk_75/rst, mode, start + seeds, eat1/eat2, map bus (master),
// point_x/y/valid, credit_valid/id, spawn_fail, busy.
module point_spawn_ctrl
    import point_spawn_ctrl_pkg::*;
#(
    parameter int MAP_W     = MAP_WIDTH,
    parameter int MAP_H     = MAP_HEIGHT,
    parameter int MAX_TRIES = POINT_MAX_TRIES
) (
    input  logic               clk_75,
    input  logic               rst,
    input  game_mode           mode,
    input  logic               start,
    input  logic [4:0]         seed_x,
    input  logic [4:0]         seed_y,
    input  logic               eat1,
    input  logic               eat2,
    point_spawn_ctrl_if.master map,
    output logic [4:0]         point_x,
    output logic [4:0]         point_y,
    output logic               point_valid,
    output logic               credit_valid,
    output logic               credit_id,
    output logic               spawn_fail,
    output logic               busy
);
    // Try counter is 4 bits wide, enough for up to 16 attempts.
    localparam logic [3:0] LAST_TRY = 4'(MAX_TRIES - 1);

    spawn_state_t state, state_n;
    logic [4:0] cx, cy, cx_n, cy_n;
    logic [4:0] px_n, py_n;
    logic [3:0] tries, tries_n;
    logic       pv_n;
    logic [4:0] rd_x, rd_y, rd_hx, rd_hy;
    logic [4:0] wr_x, wr_y, wr_hx, wr_hy;
    logic       wr_en;
    logic       game, take, grant, grant_id;

    assign game = (mode == GAME);
    assign take = game && (state == IDLE) && !start;
    assign busy = (state != IDLE);

    point_spawn_ctrl_eat_arbiter u_arb (
        .clk      (clk_75),
        .rst      (rst),
        .game     (game),
        .eat1     (eat1),
        .eat2     (eat2),
        .take     (take),
        .grant    (grant),
        .grant_id (grant_id)
    );

    // Addresses are live while in use and hold their last value otherwise.
    assign rd_x = (state == PROBE) ? cx : rd_hx;
    assign rd_y = (state == PROBE) ? cy : rd_hy;
    assign wr_x = wr_en ? cx : wr_hx;
    assign wr_y = wr_en ? cy : wr_hy;

    assign map.rd_x  = rd_x;
    assign map.rd_y  = rd_y;
    assign map.wr_en = wr_en;
    assign map.wr_x  = wr_x;
    assign map.wr_y  = wr_y;

    always_comb begin
        state_n      = state;
        cx_n         = cx;
        cy_n         = cy;
        tries_n      = tries;
        px_n         = point_x;
        py_n         = point_y;
        pv_n         = point_valid;
        credit_valid = 1'b0;
        credit_id    = 1'b0;
        spawn_fail   = 1'b0;
        wr_en        = 1'b0;
        unique case (state)
            IDLE: begin
                if (game && start) begin
                    cx_n    = fold(seed_x, MAP_W - 2);
                    cy_n    = fold(seed_y, MAP_H - 2);
                    tries_n = '0;
                    state_n = PROBE;
                end else if (grant) begin
                    credit_valid = 1'b1;
                    credit_id    = grant_id;
                    pv_n         = 1'b0;
                    cx_n         = fold(lfsr5(point_x), MAP_W - 2);
                    cy_n         = fold(lfsr5(point_y), MAP_H - 2);
                    tries_n      = '0;
                    state_n      = PROBE;
                end
            end
            PROBE: state_n = CHECK;
            CHECK: begin
                if (map.rd_tile == EMPTY) begin
                    state_n = WRITE;
                end else if (tries == LAST_TRY) begin
                    spawn_fail = 1'b1;
                    pv_n       = 1'b0;
                    state_n    = IDLE;
                end else begin
                    tries_n = tries + 4'd1;
                    cx_n    = fold(lfsr5(cx), MAP_W - 2);
                    cy_n    = fold(lfsr5(cy), MAP_H - 2);
                    state_n = PROBE;
                end
            end
            WRITE: begin
                wr_en   = 1'b1;
                px_n    = cx;
                py_n    = cy;
                pv_n    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        // Leaving the game aborts everything and suppresses side effects.
        if (!game) begin
            state_n      = IDLE;
            tries_n      = '0;
            pv_n         = 1'b0;
            credit_valid = 1'b0;
            credit_id    = 1'b0;
            spawn_fail   = 1'b0;
            wr_en        = 1'b0;
        end
    end

    always_ff @(posedge clk_75) begin
        if (rst) begin
            state       <= IDLE;
            cx          <= '0;
            cy          <= '0;
            tries       <= '0;
            point_x     <= '0;
            point_y     <= '0;
            point_valid <= 1'b0;
            rd_hx       <= '0;
            rd_hy       <= '0;
            wr_hx       <= '0;
            wr_hy       <= '0;
        end else begin
            state       <= state_n;
            cx          <= cx_n;
            cy          <= cy_n;
            tries       <= tries_n;
            point_x     <= px_n;
            point_y     <= py_n;
            point_valid <= pv_n;
            rd_hx       <= rd_x;
            rd_hy       <= rd_y;
            wr_hx       <= wr_x;
            wr_hy       <= wr_y;
        end
    end
endmodule

// File: tb/tb_point_spawn_ctrl.sv
// Self-checking bench for point_spawn_ctrl: table of seed vectors plus
// hand-written sequences, with write/credit scoreboards checked at negedge.
module tb_point_spawn_ctrl;
    import point_spawn_ctrl_pkg::*;

    logic       clk_75 = 1'b0;
    logic       rst = 1'b1;
    game_mode   mode = GAME;
    logic       start = 1'b0;
    logic [4:0] seed_x = '0;
    logic [4:0] seed_y = '0;
    logic       eat1 = 1'b0;
    logic       eat2 = 1'b0;
    logic [4:0] point_x, point_y;
    logic       point_valid, credit_valid, credit_id, spawn_fail, busy;

    point_spawn_ctrl_if bus ();

    point_spawn_ctrl dut (
        .clk_75       (clk_75),
        .rst          (rst),
        .mode         (mode),
        .start        (start),
        .seed_x       (seed_x),
        .seed_y       (seed_y),
        .eat1         (eat1),
        .eat2         (eat2),
        .map          (bus),
        .point_x      (point_x),
        .point_y      (point_y),
        .point_valid  (point_valid),
        .credit_valid (credit_valid),
        .credit_id    (credit_id),
        .spawn_fail   (spawn_fail),
        .busy         (busy)
    );

    always #5 clk_75 = ~clk_75;

    typedef struct {
        logic [4:0] x;
        logic [4:0] y;
        int         cyc;
    } wr_exp_t;

    typedef struct {
        logic id;
        int   cyc;
    } cr_exp_t;

    typedef struct {
        logic [4:0] sx, sy;
        logic [4:0] fx, fy;
        bit         block;
        logic [4:0] ex, ey;
        int         lat;
    } vec_t;

    wr_exp_t wr_q[$];
    cr_exp_t cr_q[$];
    vec_t    vecs[7];
    tile_t   tiles[32][32];

    int cyc = 0;
    int n_pass = 0;
    int n_total = 0;
    int wr_cnt = 0;
    int cr_cnt = 0;
    int fail_cnt = 0;
    int fail_cyc = 0;
    wr_exp_t we;
    cr_exp_t ce;

    always @(posedge clk_75) cyc <= cyc + 1;

    // Map register model: one-cycle read latency.
    always @(posedge clk_75) bus.rd_tile <= tiles[bus.rd_x][bus.rd_y];

    task automatic check(string nm, int act, int exp);
        n_total++;
        if (act != exp)
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        else
            n_pass++;
    endtask

    always @(negedge clk_75) begin
        if (!rst) begin
            if (bus.wr_en) begin
                wr_cnt++;
                if (wr_q.size() == 0) begin
                    check("wr_unexpected", 1, 0);
                end else begin
                    we = wr_q.pop_front();
                    check("wr_x", bus.wr_x, we.x);
                    check("wr_y", bus.wr_y, we.y);
                    check("wr_cycle", cyc, we.cyc);
                end
            end
            if (credit_valid) begin
                cr_cnt++;
                if (cr_q.size() == 0) begin
                    check("credit_unexpected", 1, 0);
                end else begin
                    ce = cr_q.pop_front();
                    check("credit_id", credit_id, ce.id);
                    check("credit_cycle", cyc, ce.cyc);
                end
            end
            if (spawn_fail) begin
                fail_cnt++;
                fail_cyc = cyc;
            end
        end
    end

    task automatic tick();
        @(posedge clk_75);
        #1;
    endtask

    task automatic run(int n);
        repeat (n) tick();
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        start = 1'b0;
        eat1  = 1'b0;
        eat2  = 1'b0;
        mode  = GAME;
        run(2);
        rst = 1'b0;
    endtask

    task automatic fill(tile_t t);
        for (int i = 0; i < 32; i++)
            for (int j = 0; j < 32; j++)
                tiles[i][j] = t;
    endtask

    task automatic push_wr(logic [4:0] x, logic [4:0] y, int c);
        wr_exp_t e;
        e.x = x;
        e.y = y;
        e.cyc = c;
        wr_q.push_back(e);
    endtask

    task automatic push_cr(logic id, int c);
        cr_exp_t e;
        e.id = id;
        e.cyc = c;
        cr_q.push_back(e);
    endtask

    // Drives start for one cycle; returns the cycle number of that cycle.
    task automatic launch(logic [4:0] sx, logic [4:0] sy, int lat,
                          logic [4:0] ex, logic [4:0] ey, bit exp_wr,
                          output int t0);
        seed_x = sx;
        seed_y = sy;
        start  = 1'b1;
        t0     = cyc;
        if (exp_wr) push_wr(ex, ey, t0 + lat);
        tick();
        start = 1'b0;
    endtask

    initial begin
        int t0, w0, c0, f0;
        vecs[0] = '{5'd5,  5'd7,  5'd6,  5'd8,  1'b0, 5'd6,  5'd8,  3};
        vecs[1] = '{5'd5,  5'd7,  5'd6,  5'd8,  1'b1, 5'd13, 5'd17, 5};
        vecs[2] = '{5'd0,  5'd0,  5'd1,  5'd1,  1'b0, 5'd1,  5'd1,  3};
        vecs[3] = '{5'd0,  5'd0,  5'd1,  5'd1,  1'b1, 5'd3,  5'd3,  5};
        vecs[4] = '{5'd31, 5'd31, 5'd2,  5'd10, 1'b0, 5'd2,  5'd10, 3};
        vecs[5] = '{5'd29, 5'd21, 5'd30, 5'd22, 1'b0, 5'd30, 5'd22, 3};
        vecs[6] = '{5'd30, 5'd22, 5'd1,  5'd1,  1'b0, 5'd1,  5'd1,  3};

        fill(EMPTY);
        do_reset();
        check("rst_busy", busy, 0);
        check("rst_point_valid", point_valid, 0);
        check("rst_point_x", point_x, 0);
        check("rst_rd_x", bus.rd_x, 0);
        check("rst_wr_x", bus.wr_x, 0);
        check("rst_credit", credit_valid, 0);

        // Reset in the middle of a spawn drops the pending write.
        w0 = wr_cnt;
        launch(5'd5, 5'd7, 3, 5'd6, 5'd8, 1'b0, t0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy", busy, 0);
        check("midrst_rd_x", bus.rd_x, 0);
        check("midrst_point_valid", point_valid, 0);
        run(6);
        check("midrst_no_wr", wr_cnt - w0, 0);

        for (int i = 0; i < 7; i++) begin
            do_reset();
            fill(EMPTY);
            if (vecs[i].block) tiles[vecs[i].fx][vecs[i].fy] = SNAKE1;
            launch(vecs[i].sx, vecs[i].sy, vecs[i].lat,
                   vecs[i].ex, vecs[i].ey, 1'b1, t0);
            check("vec_rd_x", bus.rd_x, vecs[i].fx);
            check("vec_rd_y", bus.rd_y, vecs[i].fy);
            tick();
            check("vec_rd_hold_x", bus.rd_x, vecs[i].fx);
            run(8);
            check("vec_point_x", point_x, vecs[i].ex);
            check("vec_point_y", point_y, vecs[i].ey);
            check("vec_point_valid", point_valid, 1);
            check("vec_wr_q_empty", wr_q.size(), 0);
        end

        // Every probe hits a snake: give up after MAX_TRIES probes.
        do_reset();
        fill(SNAKE2);
        f0 = fail_cnt;
        w0 = wr_cnt;
        launch(5'd5, 5'd7, 3, 5'd6, 5'd8, 1'b0, t0);
        run(24);
        check("fail_count", fail_cnt - f0, 1);
        check("fail_cycle", fail_cyc, t0 + 16);
        check("fail_point_valid", point_valid, 0);
        check("fail_no_wr", wr_cnt - w0, 0);
        check("fail_busy", busy, 0);

        // Simultaneous eats: snake1 first, then snake2 after its spawn.
        do_reset();
        fill(EMPTY);
        launch(5'd5, 5'd7, 3, 5'd6, 5'd8, 1'b1, t0);
        run(6);
        c0 = cr_cnt;
        w0 = wr_cnt;
        eat1 = 1'b1;
        eat2 = 1'b1;
        t0 = cyc;
        push_cr(1'b0, t0 + 1);
        push_cr(1'b1, t0 + 5);
        push_wr(5'd13, 5'd17, t0 + 4);
        push_wr(5'd27, 5'd2, t0 + 8);
        tick();
        eat1 = 1'b0;
        eat2 = 1'b0;
        run(12);
        check("dual_credits", cr_cnt - c0, 2);
        check("dual_writes", wr_cnt - w0, 2);
        check("dual_cr_q_empty", cr_q.size(), 0);
        check("dual_rr", dut.u_arb.rr, 0);
        check("dual_point_x", point_x, 27);
        check("dual_point_y", point_y, 2);
        check("dual_point_valid", point_valid, 1);

        // Drop to MENU during CHECK.
        do_reset();
        fill(EMPTY);
        launch(5'd5, 5'd7, 3, 5'd6, 5'd8, 1'b1, t0);
        run(6);
        w0 = wr_cnt;
        c0 = cr_cnt;
        launch(5'd5, 5'd7, 3, 5'd6, 5'd8, 1'b0, t0);
        eat1 = 1'b1;
        tick();
        eat1 = 1'b0;
        mode = MENU;
        tick();
        check("menu_busy", busy, 0);
        check("menu_point_valid", point_valid, 0);
        check("menu_pend1", dut.u_arb.pend1, 0);
        check("menu_pend2", dut.u_arb.pend2, 0);
        run(4);
        mode = GAME;
        run(8);
        check("menu_no_wr", wr_cnt - w0, 0);
        check("menu_no_credit", cr_cnt - c0, 0);

        // eat1 twice while busy merges into one credit.
        do_reset();
        fill(EMPTY);
        c0 = cr_cnt;
        t0 = cyc;
        push_wr(5'd6, 5'd8, t0 + 3);
        push_cr(1'b0, t0 + 4);
        push_wr(5'd13, 5'd17, t0 + 7);
        seed_x = 5'd5;
        seed_y = 5'd7;
        start = 1'b1;
        tick();
        start = 1'b0;
        eat1 = 1'b1;
        tick();
        eat1 = 1'b0;
        tick();
        eat1 = 1'b1;
        tick();
        eat1 = 1'b0;
        run(14);
        check("merge_credits", cr_cnt - c0, 1);
        check("merge_wr_q_empty", wr_q.size(), 0);
        check("merge_cr_q_empty", cr_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end
endmodule
